// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and issues one imem request at a time.
// It presents fetched words to IF/ID, honours stall and redirect, and latches end-of-program.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic [63:0] if_pc_out,
  output logic [31:0] if_instruction_out,
  output logic        if_valid,
  output logic        done_signal,
  output logic [63:0] fetch_count
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;

  state_t      state, state_n;
  logic [63:0] pc, pc_n, if_pc_n, cnt_n, rpc;
  logic [31:0] instr_n;
  logic        discard, discard_n, vld_n, done_n;

  assign rpc            = redirect_pc & ~64'h3;
  assign imem_req_valid = (state == S_REQ) && !reset;
  assign imem_req_addr  = pc;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    if_pc_n   = if_pc_out;
    instr_n   = if_instruction_out;
    vld_n     = if_valid;
    done_n    = done_signal;
    cnt_n     = fetch_count;
    case (state)
      S_REQ: begin
        if (imem_req_ready) begin
          // The old-PC request is already accepted; its response must be dropped.
          state_n   = S_WAIT;
          discard_n = redirect_valid;
          if (redirect_valid) pc_n = rpc;
        end else if (redirect_valid) begin
          pc_n = rpc;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (discard || redirect_valid) begin
            discard_n = 1'b0;
            if (redirect_valid) pc_n = rpc;
            state_n = S_REQ;
          end else if (imem_resp_data == 32'h0) begin
            done_n  = 1'b1;
            state_n = S_DONE;
          end else begin
            if_pc_n = pc;
            instr_n = imem_resp_data;
            vld_n   = 1'b1;
            pc_n    = pc + 64'd4;
            state_n = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_n      = rpc;
          discard_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          vld_n   = 1'b0;
          pc_n    = rpc;
          state_n = S_REQ;
        end else if (!stall) begin
          vld_n   = 1'b0;
          cnt_n   = fetch_count + 64'd1;
          state_n = S_REQ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= S_REQ;
      pc                 <= RESET_PC;
      discard            <= 1'b0;
      if_pc_out          <= 64'h0;
      if_instruction_out <= 32'h0;
      if_valid           <= 1'b0;
      done_signal        <= 1'b0;
      fetch_count        <= 64'h0;
    end else begin
      state              <= state_n;
      pc                 <= pc_n;
      discard            <= discard_n;
      if_pc_out          <= if_pc_n;
      if_instruction_out <= instr_n;
      if_valid           <= vld_n;
      done_signal        <= done_n;
      fetch_count        <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a vector table for the straight-line fetch run plus
// hand sequences for redirect, end-of-program and reset corners.
module tb_fetch_stage;
  logic        clk = 0, reset = 1;
  logic        imem_req_valid, imem_req_ready = 0;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid = 0;
  logic [31:0] imem_resp_data = 0;
  logic        redirect_valid = 0;
  logic [63:0] redirect_pc = 0;
  logic        stall = 0;
  logic [63:0] if_pc_out, fetch_count;
  logic [31:0] if_instruction_out;
  logic        if_valid, done_signal;

  fetch_stage #(.RESET_PC(64'h1000)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_pc_out(if_pc_out), .if_instruction_out(if_instruction_out),
    .if_valid(if_valid), .done_signal(done_signal), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int stall_n; logic [63:0] addr; } vec_t;
  typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;

  exp_t        sb[$];
  int          errors = 0, checks = 0;
  logic [63:0] exp_cnt = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait (bounded) for a request, check its address, accept it and answer next cycle.
  task automatic do_fetch(input logic [63:0] addr, input logic [31:0] data);
    int n = 0;
    while (!imem_req_valid && n < 20) begin tick(); n++; end
    chk("req_valid", {63'h0, imem_req_valid}, 64'h1);
    chk("req_addr", imem_req_addr, addr);
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    chk("no_req_in_wait", {63'h0, imem_req_valid}, 64'h0);
    imem_resp_valid = 1; imem_resp_data = data;
    if (data != 32'h0) sb.push_back('{pc: addr, instr: data});
    tick();
    imem_resp_valid = 0; imem_resp_data = 0;
  endtask

  // Compare the presented word with the scoreboard, optionally stall, then consume.
  task automatic present(input int stall_n);
    exp_t e;
    chk("if_valid", {63'h0, if_valid}, 64'h1);
    if (sb.size() == 0) begin
      errors++; checks++;
      $display("FAIL sb_empty: got presentation pc=%h expected none", if_pc_out);
      e = '{pc: 64'h0, instr: 32'h0};
    end else e = sb.pop_front();
    chk("if_pc", if_pc_out, e.pc);
    chk("if_instr", {32'h0, if_instruction_out}, {32'h0, e.instr});
    stall = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      tick();
      chk("stall_pc", if_pc_out, e.pc);
      chk("stall_instr", {32'h0, if_instruction_out}, {32'h0, e.instr});
      chk("stall_valid", {63'h0, if_valid}, 64'h1);
      chk("stall_noreq", {63'h0, imem_req_valid}, 64'h0);
    end
    stall = 0; tick();
    exp_cnt++;
    chk("consumed_valid", {63'h0, if_valid}, 64'h0);
    chk("fetch_count", fetch_count, exp_cnt);
  endtask

  vec_t vecs[3];

  initial begin
    vecs[0] = '{data: 32'h00500093, stall_n: 4, addr: 64'h1000};
    vecs[1] = '{data: 32'h00100113, stall_n: 0, addr: 64'h1004};
    vecs[2] = '{data: 32'h002081b3, stall_n: 0, addr: 64'h1008};

    tick(); tick();
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    reset = 0;
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_pc_out", if_pc_out, 64'h0);
    chk("rst_instr", {32'h0, if_instruction_out}, 64'h0);
    chk("rst_done", {63'h0, done_signal}, 64'h0);
    chk("rst_count", fetch_count, 64'h0);
    chk("rst_addr", imem_req_addr, 64'h1000);

    for (int i = 0; i < 3; i++) begin
      do_fetch(vecs[i].addr, vecs[i].data);
      present(vecs[i].stall_n);
    end
    chk("count3", fetch_count, 64'd3);

    // Redirect while waiting: in-flight word dropped, misaligned target forced aligned.
    chk("addr_100c", imem_req_addr, 64'h100C);
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    redirect_valid = 1; redirect_pc = 64'h2002; tick(); redirect_valid = 0;
    imem_resp_valid = 1; imem_resp_data = 32'h00000013; tick(); imem_resp_valid = 0;
    chk("drop_wait_valid", {63'h0, if_valid}, 64'h0);
    chk("drop_wait_addr", imem_req_addr, 64'h2000);
    chk("drop_wait_req", {63'h0, imem_req_valid}, 64'h1);
    tick();
    chk("drop_wait_valid2", {63'h0, if_valid}, 64'h0);

    do_fetch(64'h2000, 32'h00000013);
    present(0);

    // Redirect coincident with an accepted request.
    chk("addr_2004", imem_req_addr, 64'h2004);
    imem_req_ready = 1; redirect_valid = 1; redirect_pc = 64'h3000; tick();
    imem_req_ready = 0; redirect_valid = 0;
    imem_resp_valid = 1; imem_resp_data = 32'h00000033; tick(); imem_resp_valid = 0;
    chk("drop_acc_valid", {63'h0, if_valid}, 64'h0);
    chk("drop_acc_addr", imem_req_addr, 64'h3000);

    // Redirect in REQ with memory not ready; target is then all-ones (aligned).
    redirect_valid = 1; redirect_pc = 64'h3100; tick();
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF; redirect_valid = 0;
    chk("req_redir_addr", imem_req_addr, 64'h3100);
    do_fetch(64'h3100, 32'h00208233);
    present(0);
    redirect_valid = 1; tick(); redirect_valid = 0;
    do_fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'h00000093);
    present(0);
    chk("pc_wrap", imem_req_addr, 64'h0);

    // End-of-program word.
    do_fetch(64'h0, 32'h0);
    chk("done_set", {63'h0, done_signal}, 64'h1);
    chk("done_valid", {63'h0, if_valid}, 64'h0);
    chk("done_noreq", {63'h0, imem_req_valid}, 64'h0);
    redirect_valid = 1; redirect_pc = 64'h4000; imem_resp_valid = 1; imem_resp_data = 32'h13;
    tick(); tick();
    redirect_valid = 0; imem_resp_valid = 0;
    chk("done_sticky", {63'h0, done_signal}, 64'h1);
    chk("done_noreq2", {63'h0, imem_req_valid}, 64'h0);
    chk("done_count", fetch_count, exp_cnt);
    chk("done_nvalid", {63'h0, if_valid}, 64'h0);

    reset = 1; tick(); reset = 0; exp_cnt = 0;
    chk("done_cleared", {63'h0, done_signal}, 64'h0);
    chk("restart_addr", imem_req_addr, 64'h1000);
    chk("restart_count", fetch_count, 64'h0);

    // Reset while stalled in HOLD.
    do_fetch(64'h1000, 32'h00500093);
    chk("hold_valid", {63'h0, if_valid}, 64'h1);
    stall = 1; tick();
    reset = 1; tick();
    chk("hold_rst_noreq", {63'h0, imem_req_valid}, 64'h0);
    reset = 0; stall = 0;
    void'(sb.pop_front());
    chk("hold_rst_valid", {63'h0, if_valid}, 64'h0);
    chk("hold_rst_instr", {32'h0, if_instruction_out}, 64'h0);
    chk("hold_rst_count", fetch_count, 64'h0);
    chk("hold_rst_addr", imem_req_addr, 64'h1000);

    // Reset while waiting, then a late response that must be ignored.
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    reset = 1; tick(); reset = 0;
    imem_resp_valid = 1; imem_resp_data = 32'h00700093; tick(); imem_resp_valid = 0;
    chk("late_valid", {63'h0, if_valid}, 64'h0);
    chk("late_req", {63'h0, imem_req_valid}, 64'h1);
    chk("late_addr", imem_req_addr, 64'h1000);
    do_fetch(64'h1000, 32'h00700093);
    present(0);
    chk("sb_drained", sb.size(), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
